// File: rtl/inst_prefetch_queue.sv
// Fetch front end: issues sequential imem requests and buffers {pc, instr} pairs for IF/ID.
// Optional IPQ_BYPASS_EN forwards an ack straight to the output when the queue is empty.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [63:0]       fetch_pc_q, fetch_pc_d;
  logic [63:0]       stale_pc_q, stale_pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [63:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];

  logic ack_v;
  logic keep;
  logic bypass;
  logic q_push;
  logic q_pop;

  // An ack is only meaningful while a request is outstanding.
  assign ack_v = imem_ack & imem_req;
  assign keep  = (state_q == StBusy) & ack_v & ~redirect;

`ifdef IPQ_BYPASS_EN
  assign bypass = keep & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign q_pop  = (count_q != '0) & out_ready & ~redirect;
  // A bypassed word consumed this cycle never enters the queue.
  assign q_push = keep & ~(bypass & out_ready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (q_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (q_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(q_push) - CntW'(q_pop);
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q < DepthCnt) begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (ack_v) begin
            state_d = StIdle;
          end else begin
            // Keep driving the old address until the orphaned response returns.
            state_d    = StDiscard;
            stale_pc_d = fetch_pc_q;
          end
        end else if (ack_v) begin
          fetch_pc_d = fetch_pc_q + 64'd4;
          state_d    = (count_d < DepthCnt) ? StBusy : StIdle;
        end
      end
      StDiscard: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (ack_v)    state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      stale_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 64'd0;
        instr_q[i] <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stale_pc_q <= stale_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (q_push) begin
        pc_q[wr_ptr_q]    <= fetch_pc_q;
        instr_q[wr_ptr_q] <= imem_data;
      end
    end
  end

  assign imem_req  = (state_q != StIdle);
  assign imem_addr = (state_q == StDiscard) ? stale_pc_q : fetch_pc_q;
  assign out_valid = (count_q != '0) | bypass;
  assign out_pc    = bypass ? fetch_pc_q : pc_q[rd_ptr_q];
  assign out_instr = bypass ? imem_data  : instr_q[rd_ptr_q];

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch rules.
module tb_inst_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'd0;
`ifdef IPQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  inst_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model: fetch mode (0 idle, 1 fetching, 2 dropping), pc and a plain queue.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  int          m_mode  = 0;
  logic [63:0] m_pc    = RESET_PC;
  logic [63:0] m_stale = RESET_PC;

  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_instr;

  task automatic model_step(input logic rst, input logic r, input logic [63:0] rpc,
                            input logic ack, input logic [31:0] data, input logic rdy);
    int pre;
    bit ackv, byp;
    if (rst) begin
      m_mode = 0; m_pc = RESET_PC; m_stale = RESET_PC; mq.delete();
      return;
    end
    pre  = mq.size();
    ackv = ack && (m_mode != 0);
    byp  = Bypass && pre == 0 && m_mode == 1 && ack && !r;
    if (r) mq.delete();
    else if (pre != 0 && rdy) void'(mq.pop_front());
    case (m_mode)
      0: begin
        if (r) m_pc = rpc;
        else if (pre < DEPTH) m_mode = 1;
      end
      1: begin
        if (r) begin
          if (ackv) m_mode = 0;
          else begin m_mode = 2; m_stale = m_pc; end
          m_pc = rpc;
        end else if (ackv) begin
          if (!(byp && rdy)) mq.push_back('{m_pc, data});
          m_pc = m_pc + 64'd4;
          m_mode = (mq.size() < DEPTH) ? 1 : 0;
        end
      end
      default: begin
        if (r) m_pc = rpc;
        if (ackv) m_mode = 0;
      end
    endcase
  endtask

  task automatic cycle(input logic rst, input logic r, input logic [63:0] rpc,
                       input logic ack, input logic [31:0] data, input logic rdy);
    bit          e_valid, byp;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    @(negedge clk);
    reset = rst; redirect = r; redirect_pc = rpc;
    imem_ack = ack; imem_data = data; out_ready = rdy;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instr;
    byp     = Bypass && mq.size() == 0 && m_mode == 1 && ack && !r;
    e_valid = (mq.size() != 0) || byp;
    e_pc    = byp ? m_pc : (mq.size() != 0 ? mq[0].pc : 64'd0);
    e_instr = byp ? data : (mq.size() != 0 ? mq[0].instr : 32'd0);
    check_eq("req", s_req, m_mode != 0);
    if (m_mode != 0) check_eq("addr", s_addr, (m_mode == 2) ? m_stale : m_pc);
    check_eq("valid", s_valid, e_valid);
    if (e_valid) begin
      check_eq("out_pc", s_pc, e_pc);
      check_eq("out_instr", s_instr, e_instr);
    end
    @(posedge clk);
    model_step(rst, r, rpc, ack, data, rdy);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [63:0] seq, aseq;
    int          lat;
    logic        r, ack, rdy, rst;
    logic [63:0] rpc;

    // Reset values.
    do_reset();
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b0);
    check_eq("rst_req", s_req, 1'b0);
    check_eq("rst_addr", s_addr, RESET_PC);
    check_eq("rst_valid", s_valid, 1'b0);
    check_eq("rst_pc", s_pc, 64'd0);
    check_eq("rst_instr", s_instr, 32'd0);

    // Zero-wait memory, sink always ready.
    do_reset();
    seq = 0; aseq = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 64'd0, 1'b1, $urandom, 1'b1);
      if (s_valid) begin check_eq("zw_pc", s_pc, seq); seq += 4; end
      if (s_req) begin check_eq("zw_addr", s_addr, aseq); aseq += 4; end
    end
    check_eq("zw_count", seq, 64'd40);

    // Fill with sink stalled, then drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 64'd0, 1'b1, $urandom, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, $urandom, 1'b0);
    check_eq("fill_req", s_req, 1'b0);
    check_eq("fill_valid", s_valid, 1'b1);
    check_eq("fill_head", s_pc, 64'd0);
    seq = 0; aseq = 16;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 64'd0, 1'b1, $urandom, 1'b1);
      if (s_valid) begin check_eq("drain_pc", s_pc, seq); seq += 4; end
      if (s_req) begin check_eq("refill_addr", s_addr, aseq); aseq += 4; end
    end

    // Slow memory, redirect during the wait, stale response dropped.
    do_reset();
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 64'h100, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'hBAD0_BAD0, 1'b1);
    check_eq("disc_req", s_req, 1'b1);
    check_eq("disc_addr", s_addr, 64'd0);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("disc_drop", s_valid, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'h1234_5678, 1'b1);
    check_eq("redir_addr", s_addr, 64'h100);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("redir_pc", s_pc, 64'h100);
    check_eq("redir_instr", s_instr, 32'h1234_5678);

    // Redirect coinciding with an ack while two entries are queued.
    do_reset();
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'h22, 1'b0);
    cycle(1'b0, 1'b1, 64'h200, 1'b1, 32'h33, 1'b1);
    check_eq("rdack_pre", s_valid, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("rdack_valid", s_valid, 1'b0);
    check_eq("rdack_req", s_req, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("rdack_addr", s_addr, 64'h200);

    // Reset while a request is outstanding; late ack ignored.
    do_reset();
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check_eq("mid_req", s_req, 1'b0);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("mid_valid", s_valid, 1'b0);
    check_eq("mid_addr", s_addr, RESET_PC);

    // Empty queue ack at 0x40: same-cycle only when bypass is built in.
    do_reset();
    cycle(1'b0, 1'b1, 64'h40, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 64'd0, 1'b1, 32'hD503_201F, 1'b1);
    check_eq("byp_valid", s_valid, Bypass);
    if (s_valid) check_eq("byp_instr", s_instr, 32'hD503_201F);
    cycle(1'b0, 1'b0, 64'd0, 1'b0, 32'd0, 1'b1);
    check_eq("byp_next", s_valid, !Bypass);
    if (s_valid) check_eq("late_pc", s_pc, 64'h40);

    // Randomized traffic with variable latency, redirects and occasional reset.
    do_reset();
    lat = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF8;
      else rpc = {32'($urandom), 32'($urandom)} & ~64'h3;
      rdy = ($urandom_range(0, 3) != 0);
      if (m_mode != 0) begin
        if (lat == 0) begin ack = 1'b1; lat = $urandom_range(0, 3); end
        else begin ack = 1'b0; lat--; end
      end else begin
        ack = ($urandom_range(0, 9) == 0);
      end
      cycle(rst, r, rpc, ack, $urandom, rdy);
      check_eq("model_depth", mq.size() <= DEPTH, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
